// File: rtl/stage3_fu_sequencer.sv
// rtl/stage3_fu_sequencer.sv - execute-stage sequencer for multicycle functional units
module stage3_fu_sequencer #(
    parameter int NUM_FU  = 4,
    parameter int DATA_W  = 32,
    parameter int MAX_LAT = 64
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     issue_valid,
    input  logic [NUM_FU-1:0]        issue_fu,
    input  logic                     mem_use_stall,
    input  logic                     ex_mem_stall,
    input  logic                     ex_mem_flush,
    output logic [NUM_FU-1:0]        fu_start,
    output logic [NUM_FU-1:0]        fu_kill,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*DATA_W-1:0] fu_out,
    output logic                     ex_busy,
    output logic                     res_valid,
    output logic [DATA_W-1:0]        res_data,
    output logic                     fu_timeout
);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   act;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   cur;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DATA_W-1:0]  cur_out;
    logic               onehot;
    logic               accept;
    logic               cur_done;
    logic               flush_eff;
    logic               wd_hit;
    logic               timeout;
    logic               kill_en;

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (issue_fu[i]) issue_idx = IDX_W'(i);
        end
    end

    assign onehot = (issue_fu != '0) && ((issue_fu & (issue_fu - NUM_FU'(1))) == '0);
    assign accept = (state == IDLE) && issue_valid && !mem_use_stall && !ex_mem_flush && onehot;
    // In IDLE the FU being started is the one selected this cycle, not the stored one.
    assign cur    = (state == IDLE) ? issue_idx : act;

    always_comb begin
        cur_done = 1'b0;
        cur_out  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (IDX_W'(i) == cur) begin
                cur_done = fu_done[i];
                cur_out  = fu_out[i*DATA_W +: DATA_W];
            end
        end
    end

    assign flush_eff = ex_mem_flush && !ex_mem_stall;
    assign cnt_inc   = (cnt == CNT_W'(MAX_LAT)) ? cnt : cnt + CNT_W'(1);
    assign wd_hit    = ((state == BUSY) || (state == DRAIN)) && (cnt_inc == CNT_W'(MAX_LAT));
    // A flush or a completion in the same cycle outranks the watchdog.
    assign timeout   = wd_hit && !cur_done && !((state == BUSY) && flush_eff);
    assign kill_en   = ((state == BUSY) && flush_eff) || timeout;

    // Combinational outputs are gated by nRST so they read 0 throughout reset.
    assign fu_start   = (nRST && accept) ? issue_fu : '0;
    assign fu_kill    = (nRST && kill_en) ? (NUM_FU'(1) << act) : '0;
    assign fu_timeout = nRST && timeout;
    assign ex_busy    = nRST && ((state == DRAIN) ||
                                 (((state == BUSY) || accept) && !cur_done));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            act       <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        act <= issue_idx;
                        cnt <= '0;
                        if (cur_done) begin
                            res_data  <= cur_out;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt_inc;
                    if (flush_eff) begin
                        state <= DRAIN;
                    end else if (cur_done) begin
                        res_data  <= cur_out;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wd_hit) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!ex_mem_stall) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    cnt <= cnt_inc;
                    if (cur_done || wd_hit) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage3_fu_sequencer.sv
// tb/tb_stage3_fu_sequencer.sv - directed self-checking bench for stage3_fu_sequencer
module tb_stage3_fu_sequencer;
    logic         CLK = 1'b0;
    logic         nRST;
    logic         issue_valid;
    logic [3:0]   issue_fu;
    logic         mem_use_stall;
    logic         ex_mem_stall;
    logic         ex_mem_flush;
    logic [3:0]   fu_start;
    logic [3:0]   fu_kill;
    logic [3:0]   fu_done;
    logic [127:0] fu_out;
    logic         ex_busy;
    logic         res_valid;
    logic [31:0]  res_data;
    logic         fu_timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    stage3_fu_sequencer #(.NUM_FU(4), .DATA_W(32), .MAX_LAT(8)) dut (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_fu(issue_fu),
        .mem_use_stall(mem_use_stall), .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .fu_start(fu_start), .fu_kill(fu_kill), .fu_done(fu_done), .fu_out(fu_out),
        .ex_busy(ex_busy), .res_valid(res_valid), .res_data(res_data), .fu_timeout(fu_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; issue_valid = 1'b1; issue_fu = 4'b0010; mem_use_stall = 1'b0;
        ex_mem_stall = 1'b0; ex_mem_flush = 1'b0; fu_done = 4'b0010;
        fu_out = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        #3;
        checks++; if (fu_start !== 4'b0000) begin errors++; $display("FAIL rst_start got=%b exp=0000", fu_start); end
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", ex_busy); end
        checks++; if (res_valid !== 1'b0 || res_data !== 32'h0) begin errors++; $display("FAIL rst_res got=%b/%h exp=0/0", res_valid, res_data); end
        checks++; if (fu_kill !== 4'b0000 || fu_timeout !== 1'b0) begin errors++; $display("FAIL rst_kill got=%b/%b exp=0000/0", fu_kill, fu_timeout); end
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000; fu_done = 4'b0000;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_single_cycle();
        issue_valid = 1'b1; issue_fu = 4'b0010; fu_done = 4'b0010;
        fu_out[63:32] = 32'hDEADBEEF;
        @(negedge CLK);
        checks++; if (fu_start !== 4'b0010) begin errors++; $display("FAIL sc_start got=%b exp=0010", fu_start); end
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL sc_busy got=%b exp=0", ex_busy); end
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000; fu_done = 4'b0000;
        @(negedge CLK);
        checks++; if (fu_start !== 4'b0000) begin errors++; $display("FAIL sc_start_once got=%b exp=0000", fu_start); end
        checks++; if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_res got=%b/%h exp=1/deadbeef", res_valid, res_data); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sc_consume got=%b exp=0", res_valid); end
        last_res = 32'hDEADBEEF;
    endtask

    task automatic test_multicycle();
        int busy_cycles = 0;
        issue_valid = 1'b1; issue_fu = 4'b0100; fu_done = 4'b0000;
        fu_out[95:64] = 32'h12345678; fu_out[31:0] = 32'h0BADF00D;
        for (int c = 0; c < 5; c++) begin
            fu_done = (c == 2) ? 4'b0001 : 4'b0000;
            @(negedge CLK);
            if (ex_busy === 1'b1) busy_cycles++;
            if (c == 1) begin
                checks++; if (fu_start !== 4'b0000) begin errors++; $display("FAIL mc_start_once got=%b exp=0000", fu_start); end
            end
            tick();
            issue_valid = 1'b0; issue_fu = 4'b0000;
        end
        checks++; if (busy_cycles != 5) begin errors++; $display("FAIL mc_busy_len got=%0d exp=5", busy_cycles); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mc_foreign_done got=%b exp=0", res_valid); end
        fu_done = 4'b0100;
        @(negedge CLK);
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL mc_busy_done got=%b exp=0", ex_busy); end
        tick();
        fu_done = 4'b0000;
        @(negedge CLK);
        checks++; if (res_valid !== 1'b1 || res_data !== 32'h12345678) begin errors++; $display("FAIL mc_res got=%b/%h exp=1/12345678", res_valid, res_data); end
        tick();
        last_res = 32'h12345678;
    endtask

    task automatic test_hold_stall();
        issue_valid = 1'b1; issue_fu = 4'b0001; fu_done = 4'b0001;
        fu_out[31:0] = 32'hA5A5A5A5;
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000; fu_done = 4'b0000;
        fu_out[31:0] = 32'h5A5A5A5A;
        ex_mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ex_mem_flush = (c == 1);
            @(negedge CLK);
            checks++; if (res_valid !== 1'b1 || res_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL hold_stable c=%0d got=%b/%h exp=1/a5a5a5a5", c, res_valid, res_data); end
            checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL hold_busy c=%0d got=%b exp=0", c, ex_busy); end
            tick();
        end
        ex_mem_stall = 1'b0; ex_mem_flush = 1'b0;
        @(negedge CLK);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_drop got=%b exp=1", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_clear got=%b exp=0", res_valid); end
        last_res = 32'hA5A5A5A5;
    endtask

    task automatic test_flush_busy();
        issue_valid = 1'b1; issue_fu = 4'b0001; fu_done = 4'b0000;
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000;
        tick();
        ex_mem_flush = 1'b1; fu_done = 4'b0001; fu_out[31:0] = 32'hCAFEF00D;
        @(negedge CLK);
        checks++; if (fu_kill !== 4'b0001) begin errors++; $display("FAIL fl_kill got=%b exp=0001", fu_kill); end
        tick();
        ex_mem_flush = 1'b0; fu_done = 4'b0000;
        issue_valid = 1'b1; issue_fu = 4'b1000;
        @(negedge CLK);
        checks++; if (fu_kill !== 4'b0000) begin errors++; $display("FAIL fl_kill_once got=%b exp=0000", fu_kill); end
        checks++; if (fu_start !== 4'b0000) begin errors++; $display("FAIL fl_drain_issue got=%b exp=0000", fu_start); end
        checks++; if (ex_busy !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL fl_drain got=%b/%b exp=1/0", ex_busy, res_valid); end
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000; fu_done = 4'b0001;
        tick();
        fu_done = 4'b0000;
        @(negedge CLK);
        checks++; if (res_valid !== 1'b0 || res_data !== last_res) begin errors++; $display("FAIL fl_discard got=%b/%h exp=0/%h", res_valid, res_data, last_res); end
        checks++; if (ex_busy !== 1'b0) begin errors++; $display("FAIL fl_idle got=%b exp=0", ex_busy); end
    endtask

    task automatic test_watchdog();
        issue_valid = 1'b1; issue_fu = 4'b1000; fu_done = 4'b0000;
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000;
        for (int k = 1; k < 8; k++) begin
            @(negedge CLK);
            checks++; if (fu_timeout !== 1'b0 || ex_busy !== 1'b1) begin errors++; $display("FAIL wd_early k=%0d got=%b/%b exp=0/1", k, fu_timeout, ex_busy); end
            tick();
        end
        @(negedge CLK);
        checks++; if (fu_timeout !== 1'b1 || fu_kill !== 4'b1000) begin errors++; $display("FAIL wd_fire got=%b/%b exp=1/1000", fu_timeout, fu_kill); end
        tick();
        @(negedge CLK);
        checks++; if (fu_timeout !== 1'b0 || fu_kill !== 4'b0000) begin errors++; $display("FAIL wd_once got=%b/%b exp=0/0000", fu_timeout, fu_kill); end
        checks++; if (ex_busy !== 1'b0 || res_valid !== 1'b0 || res_data !== last_res) begin errors++; $display("FAIL wd_after got=%b/%b/%h exp=0/0/%h", ex_busy, res_valid, res_data, last_res); end
    endtask

    task automatic test_illegal_and_reset();
        issue_valid = 1'b1; issue_fu = 4'b0110; fu_done = 4'b0110;
        @(negedge CLK);
        checks++; if (fu_start !== 4'b0000 || ex_busy !== 1'b0) begin errors++; $display("FAIL ill_multi got=%b/%b exp=0000/0", fu_start, ex_busy); end
        tick();
        issue_fu = 4'b0000;
        @(negedge CLK);
        checks++; if (fu_start !== 4'b0000 || res_valid !== 1'b0) begin errors++; $display("FAIL ill_zero got=%b/%b exp=0000/0", fu_start, res_valid); end
        tick();
        issue_fu = 4'b0001; fu_done = 4'b0000; mem_use_stall = 1'b1;
        @(negedge CLK);
        checks++; if (fu_start !== 4'b0000) begin errors++; $display("FAIL ill_mem_stall got=%b exp=0000", fu_start); end
        tick();
        mem_use_stall = 1'b0; issue_fu = 4'b0100;
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000;
        @(negedge CLK);
        checks++; if (ex_busy !== 1'b1) begin errors++; $display("FAIL rs_busy got=%b exp=1", ex_busy); end
        issue_valid = 1'b1; issue_fu = 4'b0100;
        #1 nRST = 1'b0;
        #1;
        checks++; if (fu_start !== 4'b0 || fu_kill !== 4'b0 || ex_busy !== 1'b0 || fu_timeout !== 1'b0) begin errors++; $display("FAIL rs_outs got=%b/%b/%b/%b exp=0", fu_start, fu_kill, ex_busy, fu_timeout); end
        checks++; if (res_valid !== 1'b0 || res_data !== 32'h0) begin errors++; $display("FAIL rs_res got=%b/%h exp=0/0", res_valid, res_data); end
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        checks++; if (fu_start !== 4'b0100) begin errors++; $display("FAIL rs_reissue got=%b exp=0100", fu_start); end
        tick();
        issue_valid = 1'b0; issue_fu = 4'b0000;
    endtask

    initial begin
        last_res = 32'h0;
        test_reset();
        test_single_cycle();
        test_multicycle();
        test_hold_stall();
        test_flush_busy();
        test_watchdog();
        test_illegal_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
